rf_wport_arbiter: RTL and testbench
===================================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the register file's single write port between the pipeline WB stage and the multi-cycle mul/div unit (MDU).
//  - Buffers MDU results in a small FIFO; WB always has priority.
//  - Keeps a busy scoreboard of MDU destinations so decode can stall RAW/WAW hazards.
//  - Sits between the WB/MDU stages and the register file write port (RegWr/addrW/BusW).
// PARAMETERS
//  DEPTH      2   MDU result FIFO entries (power of 2, >=2)
//  STARVE_MAX 4   consecutive ungranted cycles before starvation stall (only with RF_ARB_STARVE_EN)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  wb_we      in   1   WB stage write request (no backpressure)
//  wb_addr    in   5   WB destination
//  wb_data    in   32  WB write data
//  iss_valid  in   1   MDU op issued this cycle
//  iss_addr   in   5   destination of issued MDU op
//  mdu_valid  in   1   MDU result valid
//  mdu_ready  out  1   FIFO can accept (= !full)
//  mdu_addr   in   5   MDU result destination
//  mdu_data   in   32  MDU result data
//  rf_we      out  1   to register file RegWr
//  rf_addr    out  5   to register file addrW
//  rf_data    out  32  to register file BusW
//  sb_busy    out  32  bit n set: MDU result for rN outstanding
//  stall_req  out  1   pipeline stall request (0 without RF_ARB_STARVE_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, sb_busy=0, starve count=0, stall_req=0. Outputs: rf_we=0, mdu_ready=1.
//    Reset mid-operation discards buffered results and clears all busy bits.
//  - Handshake: MDU push when mdu_valid && mdu_ready. Data must stay stable while valid && !ready.
//  - wb_act = wb_we && wb_addr!=0.
//  - Grant, combinational, 0-cycle latency:
//    - stall_req=1 and FIFO non-empty -> head.
//    - otherwise wb_act -> WB.
//    - otherwise FIFO non-empty -> head.
//  - Head pops on the cycle it is granted. A push to an empty FIFO is written on posedge and is grantable the next cycle (no bypass).
//  - rf_we=1 only for a granted write with addr!=0. An MDU entry to r0 pops silently with rf_we=0.
//  - FIFO full: mdu_ready=0. Push and pop in the same cycle when full are not allowed (ready is computed from the current count).
//  - Scoreboard:
//    - iss_valid sets sb_busy[iss_addr].
//    - FIFO-granted write clears sb_busy[head.addr].
//    - Same-cycle set and clear of the same bit: set wins.
//    - iss_addr=0 is ignored.
//    - WB writes do not touch sb_busy.
//    - Issue to an already-busy register is illegal (assertion); decode stalls on sb_busy.
//  - Arithmetic: count is $clog2(DEPTH)+1 bits; read and write pointers wrap modulo DEPTH.
// CONFIGURATION
//  RF_ARB_STARVE_EN defined:
//    - Registered counter increments each cycle the FIFO is non-empty and the head is not granted; it clears on grant or when the FIFO is empty.
//    - When count reaches STARVE_MAX, stall_req is set at the next posedge and held until the FIFO is empty.
//    - While stall_req=1, upstream must hold wb_we=0 (assertion); the head wins regardless.
//  Undefined: no counter; stall_req tied 0; WB has absolute priority.
// STRUCTURE
//  Package rf_arb_pkg:
//    - REG_AW=5, DATA_W=32
//    - typedef struct packed {logic [4:0] addr; logic [31:0] data;} rf_wr_t
//  Sub-module rf_arb_fifo: parameterised sync FIFO of rf_wr_t with push, pop, head, full, empty.
//  Top level holds grant mux, scoreboard and starve counter.
// TESTING
//  - Reset: hold rst_n=0 mid-stream with 2 FIFO entries and sb_busy=0x0000_0100.
//    -> FIFO empty, sb_busy=0, rf_we=0, mdu_ready=1 with no clock edge needed.
//  - Idle-port drain: iss r5; MDU push (5,0xDEAD_BEEF); wb_we=0.
//    -> next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; sb_busy[5] clears the following cycle.
//  - Priority: FIFO holds (7,0x11); wb_we=1 (3,0x22) for 3 cycles.
//    -> rf writes r3 each cycle; r7 is written on the first wb_we=0 cycle.
//  - Full: push 2 results while WB is busy.
//    -> mdu_ready=0; a 3rd result is held, not lost, and enters when a slot frees.
//  - r0 handling and set/clear race:
//    - wb (0,x) -> rf_we=0 and the FIFO head drains.
//    - iss r9 in the same cycle the head (9,..) writes -> sb_busy[9] stays 1.
//  - With RF_ARB_STARVE_EN, STARVE_MAX=4, wb_we=1 continuously:
//    -> stall_req rises after the 4th ungranted cycle.
//    -> after the bench drops wb_we, the head is written and stall_req falls once the FIFO is empty.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
package rf_arb_pkg;
  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/rf_arb_fifo.sv
// Synchronous FIFO of rf_wr_t entries; DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  rf_wr_t        din,
  input  logic          pop,
  output rf_wr_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  rf_wr_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between WB and buffered MDU results, and tracks
// outstanding MDU destinations. Optional head-starvation stall: RF_ARB_STARVE_EN.
module rf_wport_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_addr,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic [31:0]       sb_busy,
  output logic              stall_req
);
  localparam int CW = $clog2(DEPTH) + 1;

  rf_wr_t        head;
  logic          full, empty, push, fifo_gnt, wb_gnt, wb_act;
  logic [CW-1:0] count;
  logic [31:0]   sb_next;

  assign wb_act    = wb_we && (wb_addr != '0);
  assign mdu_ready = !full;
  assign push      = mdu_valid && !full;

  // Head wins when starving; otherwise WB has priority and the FIFO fills gaps.
  assign fifo_gnt = !empty && (stall_req || !wb_act);
  assign wb_gnt   = wb_act && !fifo_gnt;

  // Gated by rst_n so the port is quiet for the whole reset window.
  assign rf_we   = rst_n && (wb_gnt || (fifo_gnt && head.addr != '0));
  assign rf_addr = fifo_gnt ? head.addr : wb_addr;
  assign rf_data = fifo_gnt ? head.data : wb_data;

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ('{addr: mdu_addr, data: mdu_data}),
    .pop   (fifo_gnt),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Clear first, then set, so a same-cycle issue to the retiring register wins.
  always_comb begin
    sb_next = sb_busy;
    if (fifo_gnt) sb_next[head.addr] = 1'b0;
    if (iss_valid && iss_addr != '0) sb_next[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_busy <= '0;
    else        sb_busy <= sb_next;
  end

`ifdef RF_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] starve_cnt;
  logic           head_wait, drains;

  assign head_wait = !empty && !fifo_gnt;
  assign drains    = empty || (count == CW'(1) && fifo_gnt && !push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (!head_wait)                           starve_cnt <= '0;
      else if (starve_cnt != SCW'(STARVE_MAX))  starve_cnt <= starve_cnt + SCW'(1);
      // Raise on the edge that takes the counter to STARVE_MAX.
      if (drains)                                                  stall_req <= 1'b0;
      else if (head_wait && starve_cnt >= SCW'(STARVE_MAX - 1))    stall_req <= 1'b1;
    end
  end

  a_no_wb_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
    stall_req |-> !wb_we);
`else
  assign stall_req = 1'b0;
`endif

`ifndef SYNTHESIS
  a_iss_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (iss_valid && iss_addr != '0 && sb_busy[iss_addr])
      |-> (fifo_gnt && head.addr == iss_addr));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
`endif
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed, table-driven bench for rf_wport_arbiter plus hand-written reset
// and (when RF_ARB_STARVE_EN is defined) starvation sequences.
module tb_rf_wport_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we, iss_valid, mdu_valid;
  logic [4:0]  wb_addr, iss_addr, mdu_addr;
  logic [31:0] wb_data, mdu_data;
  logic        mdu_ready, rf_we, stall_req;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, sb_busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rf_wport_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .sb_busy(sb_busy), .stall_req(stall_req)
  );

  typedef struct {
    logic        wb_we;  logic [4:0] wb_addr;  logic [31:0] wb_data;
    logic        iss;    logic [4:0] iss_addr;
    logic        mv;     logic [4:0] m_addr;   logic [31:0] m_data;
    logic        e_we;   logic [4:0] e_addr;   logic [31:0] e_data;
    logic        e_rdy;  logic [31:0] e_sb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic i, input logic [4:0] ia,
                              input logic m, input logic [4:0] ma, input logic [31:0] md,
                              input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                              input logic er, input logic [31:0] es);
    vec_t v;
    v.wb_we = w; v.wb_addr = wa; v.wb_data = wd;
    v.iss = i; v.iss_addr = ia;
    v.mv = m; v.m_addr = ma; v.m_data = md;
    v.e_we = ew; v.e_addr = ea; v.e_data = ed;
    v.e_rdy = er; v.e_sb = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic i, input logic [4:0] ia,
                       input logic m, input logic [4:0] ma, input logic [31:0] md);
    wb_we = w; wb_addr = wa; wb_data = wd;
    iss_valid = i; iss_addr = ia;
    mdu_valid = m; mdu_addr = ma; mdu_data = md;
  endtask

  initial begin
    // Each row is one cycle; expectations are sampled before that cycle's posedge.
    //               wb               iss        mdu                 exp we/addr/data       rdy  sb
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           0, 0,  0,           1, 32'h0));
    // idle-port drain
    tbl.push_back(mk(0, 0, 0,         1, 5,  1, 5,  32'hDEADBEEF, 0, 0, 0,           1, 32'h0));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           1, 5,  32'hDEADBEEF, 1, 32'h20));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           0, 0,  0,           1, 32'h0));
    // WB priority over a buffered result
    tbl.push_back(mk(0, 0, 0,         1, 7,  1, 7,  32'h11,      0, 0,  0,           1, 32'h0));
    tbl.push_back(mk(1, 3, 32'h22,    0, 0,  0, 0,  0,           1, 3,  32'h22,      1, 32'h80));
    tbl.push_back(mk(1, 3, 32'h22,    0, 0,  0, 0,  0,           1, 3,  32'h22,      1, 32'h80));
    tbl.push_back(mk(1, 3, 32'h22,    0, 0,  0, 0,  0,           1, 3,  32'h22,      1, 32'h80));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           1, 7,  32'h11,      1, 32'h80));
    // full FIFO holds a third result
    tbl.push_back(mk(1, 3, 32'h22,    0, 0,  1, 10, 32'hA,       1, 3,  32'h22,      1, 32'h0));
    tbl.push_back(mk(1, 3, 32'h22,    0, 0,  1, 11, 32'hB,       1, 3,  32'h22,      1, 32'h0));
    tbl.push_back(mk(1, 3, 32'h22,    0, 0,  1, 12, 32'hC,       1, 3,  32'h22,      0, 32'h0));
    tbl.push_back(mk(1, 3, 32'h22,    0, 0,  1, 12, 32'hC,       1, 3,  32'h22,      0, 32'h0));
    tbl.push_back(mk(0, 0, 0,         0, 0,  1, 12, 32'hC,       1, 10, 32'hA,       0, 32'h0));
    tbl.push_back(mk(0, 0, 0,         0, 0,  1, 12, 32'hC,       1, 11, 32'hB,       1, 32'h0));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           1, 12, 32'hC,       1, 32'h0));
    // r0 entries and WB to r0
    tbl.push_back(mk(0, 0, 0,         0, 0,  1, 0,  32'h55,      0, 0,  0,           1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h99,    0, 0,  1, 4,  32'h44,      0, 0,  0,           1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h99,    0, 0,  0, 0,  0,           1, 4,  32'h44,      1, 32'h0));
    // set/clear race on r9
    tbl.push_back(mk(0, 0, 0,         0, 0,  1, 9,  32'h99,      0, 0,  0,           1, 32'h0));
    tbl.push_back(mk(0, 0, 0,         1, 9,  0, 0,  0,           1, 9,  32'h99,      1, 32'h0));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           0, 0,  0,           1, 32'h200));
    tbl.push_back(mk(0, 0, 0,         0, 0,  1, 9,  32'h1,       0, 0,  0,           1, 32'h200));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           1, 9,  32'h1,       1, 32'h200));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           0, 0,  0,           1, 32'h0));
    // WB writes leave the scoreboard alone
    tbl.push_back(mk(1, 6, 32'h66,    1, 6,  0, 0,  0,           1, 6,  32'h66,      1, 32'h0));
    tbl.push_back(mk(1, 6, 32'h67,    0, 0,  0, 0,  0,           1, 6,  32'h67,      1, 32'h40));
    tbl.push_back(mk(0, 0, 0,         0, 0,  1, 6,  32'h68,      0, 0,  0,           1, 32'h40));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           1, 6,  32'h68,      1, 32'h40));
    tbl.push_back(mk(0, 0, 0,         0, 0,  0, 0,  0,           0, 0,  0,           1, 32'h0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset_rf_we", 32'(rf_we), 32'h0);
    check("reset_ready", 32'(mdu_ready), 32'h1);
    check("reset_sb", sb_busy, 32'h0);
    check("reset_stall", 32'(stall_req), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      drive(tbl[k].wb_we, tbl[k].wb_addr, tbl[k].wb_data, tbl[k].iss, tbl[k].iss_addr,
            tbl[k].mv, tbl[k].m_addr, tbl[k].m_data);
      #1;
      check($sformatf("v%0d_rf_we", k), 32'(rf_we), 32'(tbl[k].e_we));
      if (tbl[k].e_we) begin
        check($sformatf("v%0d_rf_addr", k), 32'(rf_addr), 32'(tbl[k].e_addr));
        check($sformatf("v%0d_rf_data", k), rf_data, tbl[k].e_data);
      end
      check($sformatf("v%0d_ready", k), 32'(mdu_ready), 32'(tbl[k].e_rdy));
      check($sformatf("v%0d_sb", k), sb_busy, tbl[k].e_sb);
      check($sformatf("v%0d_stall", k), 32'(stall_req), 32'h0);
    end

    // Mid-stream reset with two buffered results and r8 busy.
    @(negedge clk);
    drive(1, 3, 32'h22, 1, 8, 1, 8, 32'h1);
    @(negedge clk);
    drive(1, 3, 32'h22, 0, 0, 1, 2, 32'h2);
    @(negedge clk);
    drive(1, 3, 32'h22, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst_ready", 32'(mdu_ready), 32'h0);
    check("pre_rst_sb", sb_busy, 32'h100);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rf_we", 32'(rf_we), 32'h0);
    check("mid_rst_ready", 32'(mdu_ready), 32'h1);
    check("mid_rst_sb", sb_busy, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_rf_we", 32'(rf_we), 32'h0);
    @(negedge clk);
    #1;
    check("post_rst_rf_we2", 32'(rf_we), 32'h0);
    check("post_rst_ready", 32'(mdu_ready), 32'h1);

`ifdef RF_ARB_STARVE_EN
    begin
      int  ungr = 0;
      logic seen = 1'b0;
      @(negedge clk);
      drive(1, 3, 32'h22, 0, 0, 1, 13, 32'hD);
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge clk);
        mdu_valid = 1'b0;
        #1;
        if (stall_req) seen = 1'b1;
        else           ungr++;
      end
      check("starve_seen", 32'(seen), 32'h1);
      check("starve_cycles", 32'(ungr), 32'd4);
      wb_we = 1'b0;
      #1;
      check("starve_rf_we", 32'(rf_we), 32'h1);
      check("starve_rf_addr", 32'(rf_addr), 32'd13);
      check("starve_rf_data", rf_data, 32'hD);
      @(negedge clk);
      #1;
      check("starve_stall_fall", 32'(stall_req), 32'h0);
      check("starve_ready", 32'(mdu_ready), 32'h1);
      check("starve_idle_we", 32'(rf_we), 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
